// File: rtl/simmem_read_responder.sv
// Simulated-memory read responder: accepts one read-address request at a time and
// answers it with a short burst of tagged, deterministic read-data beats.

package simmem_pkg;

    parameter int unsigned MaxBurstLength = 4;

    typedef enum logic [1:0] {
        BurstFixed = 2'd0,
        BurstIncr  = 2'd1,
        BurstWrap  = 2'd2,
        BurstRsvd  = 2'd3
    } burst_type_e;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] addr;
        logic [7:0] burst_length;
        logic [2:0] burst_size;
        logic [1:0] burst_type;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [1:0] region;
    } read_addr_req_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  response;
        logic        last;
        logic [1:0]  user;
    } read_data_resp_t;

endpackage

module simmem_read_responder
    import simmem_pkg::*;
#(
    parameter int unsigned MaxBurstLen = simmem_pkg::MaxBurstLength,
    parameter logic [7:0]  DataTag     = 8'hA5
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            raddr_in_valid_i,
    output logic            raddr_in_ready_o,
    input  read_addr_req_t  raddr_in_i,

    output logic            rdata_out_valid_o,
    input  logic            rdata_out_ready_i,
    output read_data_resp_t rdata_out_o
);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e     state_q, state_d;
    logic [3:0] id_q, id_d;
    logic [7:0] cur_addr_q, cur_addr_d;
    logic [2:0] burst_size_q, burst_size_d;
    logic [1:0] burst_type_q, burst_type_d;
    logic [8:0] beat_idx_q, beat_idx_d;
    logic [8:0] beat_count_q, beat_count_d;

    logic [8:0] req_beats;
    logic [8:0] max_beats;
    logic       last_beat;
    logic [7:0] addr_step;

    // Fields the responder does not model.
    logic unused_req_fields;
    assign unused_req_fields = ^{raddr_in_i.lock, raddr_in_i.cache, raddr_in_i.prot,
                                 raddr_in_i.qos, raddr_in_i.region};

    // 9-bit sum so burst_length=255 yields 256 before clamping.
    assign req_beats = {1'b0, raddr_in_i.burst_length} + 9'd1;
    assign max_beats = 9'(MaxBurstLen);
    assign last_beat = (beat_idx_q == beat_count_q - 9'd1);
    assign addr_step = 8'(8'd1 << burst_size_q);

    always_comb begin
        state_d           = state_q;
        id_d              = id_q;
        cur_addr_d        = cur_addr_q;
        burst_size_d      = burst_size_q;
        burst_type_d      = burst_type_q;
        beat_idx_d        = beat_idx_q;
        beat_count_d      = beat_count_q;
        raddr_in_ready_o  = 1'b0;
        rdata_out_valid_o = 1'b0;
        rdata_out_o       = '0;

        unique case (state_q)
            StIdle: begin
                raddr_in_ready_o = 1'b1;
                if (raddr_in_valid_i) begin
                    id_d         = raddr_in_i.id;
                    cur_addr_d   = raddr_in_i.addr;
                    burst_size_d = raddr_in_i.burst_size;
                    burst_type_d = raddr_in_i.burst_type;
                    beat_idx_d   = '0;
                    beat_count_d = (req_beats < max_beats) ? req_beats : max_beats;
                    state_d      = StBurst;
                end
            end
            StBurst: begin
                rdata_out_valid_o    = 1'b1;
                rdata_out_o.id       = id_q;
                rdata_out_o.data     = {4'h0, id_q, cur_addr_q, beat_idx_q[7:0], DataTag};
                rdata_out_o.response = 2'b00;
                rdata_out_o.last     = last_beat;
                if (rdata_out_ready_i) begin
                    beat_idx_d = beat_idx_q + 9'd1;
                    // WRAP behaves as INCR; reserved behaves as FIXED.
                    if (burst_type_q == BurstIncr || burst_type_q == BurstWrap) begin
                        cur_addr_d = cur_addr_q + addr_step;
                    end
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            id_q         <= '0;
            cur_addr_q   <= '0;
            burst_size_q <= '0;
            burst_type_q <= '0;
            beat_idx_q   <= '0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            cur_addr_q   <= cur_addr_d;
            burst_size_q <= burst_size_d;
            burst_type_q <= burst_type_d;
            beat_idx_q   <= beat_idx_d;
            beat_count_q <= beat_count_d;
        end
    end

endmodule

// File: doc/simmem_read_responder.md
SIMMEM_READ_RESPONDER -- requirements
Module: simmem_read_responder

Interface
REQ-001 SHALL have parameter MaxBurstLen, default simmem_pkg::MaxBurstLength (4), maximum number of beats emitted per request.
REQ-002 SHALL have parameter DataTag, default 8'hA5, constant low byte of every data beat.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port raddr_in_valid_i  input  1  read-address request valid.
REQ-006 SHALL have port raddr_in_ready_o  output  1  responder accepts request.
REQ-007 SHALL have port raddr_in_i  input  read_addr_req_t (39)  read-address request.
REQ-008 SHALL have port rdata_out_valid_o  output  1  read-data beat valid.
REQ-009 SHALL have port rdata_out_ready_i  input  1  downstream accepts beat.
REQ-010 SHALL have port rdata_out_o  output  read_data_resp_t (41)  read-data beat.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, BURST.
REQ-012 In IDLE: raddr_in_ready_o=1, rdata_out_valid_o=0.
REQ-013 In BURST: raddr_in_ready_o=0, rdata_out_valid_o=1.
REQ-014 Address handshake (valid&ready in IDLE) SHALL latch id, addr, burst_size and burst_type, set beat index to 0, and enter BURST next cycle.
REQ-015 Beat count SHALL be min(burst_length+1, MaxBurstLen), computed 9 bits wide so burst_length=255 does not overflow.
REQ-016 The first beat SHALL be valid the cycle after the address handshake (latency 1).
REQ-017 Beat fields: id=latched id; data={4'h0, id, cur_addr, beat_idx[7:0], DataTag}; response=0 (OKAY); last=1 iff beat_idx==beat_count-1.
REQ-018 cur_addr SHALL start at the latched addr; after each beat handshake, FIXED (burst_type 0) keeps it; INCR (1) and WRAP (2, treated as INCR) add 1<<burst_size modulo 256; reserved (3) is treated as FIXED.
REQ-019 rdata_out_o and rdata_out_valid_o SHALL remain stable while valid=1 and ready=0.
REQ-020 A beat handshake SHALL increment beat_idx; a handshake on the last beat SHALL return the FSM to IDLE next cycle.
REQ-021 A new request SHALL NOT be accepted in the cycle of the last-beat handshake; there is at least one IDLE cycle between bursts.
REQ-022 raddr_in_i fields other than id, addr, burst_length, burst_size and burst_type SHALL be ignored.
REQ-023 When rdata_out_valid_o=0, rdata_out_o SHALL be all-zero.

Reset
REQ-024 With rst_i=1 at a clock edge: FSM->IDLE, beat_idx=0, latched fields=0; after the edge raddr_in_ready_o=1, rdata_out_valid_o=0, rdata_out_o=0.
REQ-025 Reset mid-burst SHALL abandon the burst with no further beats emitted; a request presented during reset SHALL NOT be accepted.

Verification
REQ-026 Reset, then id=3, addr=8'h10, burst_length=3, size=2, INCR with ready_i held 1 -> 4 beats on consecutive cycles, starting the cycle after the handshake; data 32'h0310_00A5, 0314_01A5, 0318_02A5, 031C_03A5; last only on the 4th beat; then IDLE.
REQ-027 burst_length=0, FIXED, addr=8'hFF, id=0 -> single beat with data 32'h00FF_00A5, last=1.
REQ-028 burst_length=255 -> exactly 4 beats; beat 4 has last=1.
REQ-029 INCR, addr=8'hFC, size=2, burst_length=2 -> cur_addr FC, 00, 04 (wraps modulo 256).
REQ-030 Random ready_i backpressure during a 4-beat burst -> output is stable while stalled, no beat is lost or duplicated, and raddr_in_ready_o=0 until the cycle after the last handshake.
REQ-031 Assert rst_i after the 2nd beat handshake -> valid_o=0 the next cycle, ready_o=1, and the next request restarts from beat 0.
